// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter (dmem_arbiter, rr_arb2).
// Round-robin arbitration is enabled by defining DMEM_ARB_RR_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // Size code 3 is deliberately folded into the word case.
  function automatic logic [3:0] size_to_be(input logic [1:0] size);
    case (size)
      SZ_B:    return BE_B;
      SZ_H:    return BE_H;
      default: return BE_W;
    endcase
  endfunction

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way grant logic: bit 0 = core port C, bit 1 = DMA port D.
// DMEM_ARB_RR_EN selects round-robin on ties; otherwise C has fixed priority.
module rr_arb2
  import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
  input  logic       clk,
  input  logic       reset,
  input  logic       accept,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef DMEM_ARB_RR_EN
  owner_e last_grant_q;
  owner_e last_grant_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant_q == OWN_D) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = gnt[1] ? OWN_D : OWN_C;
    end
  end

  // Reset to D so the first tie after reset goes to the core.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= OWN_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0];
    gnt[1] = req[1] & ~req[0];
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between core (C) and DMA/debug loader (D):
// IDLE -> ACCESS -> RESP, one access in flight. Optional macro: DMEM_ARB_RR_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req_valid,
  output logic              c_req_ready,
  input  logic              c_we,
  input  logic [1:0]        c_size,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_rsp_valid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  owner_e            owner_q, owner_d;

  logic [1:0]        gnt;
  logic              idle, c_acc, d_acc, accept;
  logic              in_access, in_resp;
  logic [DATA_W-1:0] rsp_data;

  rr_arb2 u_arb (
`ifdef DMEM_ARB_RR_EN
    .clk    (clk),
    .reset  (reset),
    .accept (accept),
`endif
    .req    ({d_req_valid, c_req_valid}),
    .gnt    (gnt)
  );

  // Handshake: a request transfers on a cycle where valid and ready are both
  // high; ready is only offered in IDLE, never during reset, to one winner.
  always_comb begin
    idle        = (state_q == IDLE) & ~reset;
    c_req_ready = idle & gnt[0];
    d_req_ready = idle & gnt[1];
    c_acc       = c_req_valid & c_req_ready;
    d_acc       = d_req_valid & d_req_ready;
    accept      = c_acc | d_acc;
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACCESS;
          owner_d = d_acc ? OWN_D : OWN_C;
          we_d    = d_acc ? d_we    : c_we;
          size_d  = d_acc ? d_size  : c_size;
          addr_d  = d_acc ? d_addr  : c_addr;
          wdata_d = d_acc ? d_wdata : c_wdata;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= OWN_C;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
    end
  end

  // Outputs are gated by reset so an aborted transaction never strobes or responds.
  always_comb begin
    in_access = (state_q == ACCESS) & ~reset;
    in_resp   = (state_q == RESP) & ~reset;
    mem_en    = in_access;
    mem_we    = in_access & we_q;
    mem_be    = in_access ? size_to_be(size_q) : 4'b0000;
    mem_addr  = in_access ? addr_q : '0;
    mem_wdata = in_access ? wdata_q : '0;
    rsp_data  = we_q ? '0 : (mem_rdata & be_to_mask(size_to_be(size_q)));
    c_rsp_valid = in_resp & (owner_q == OWN_C);
    d_rsp_valid = in_resp & (owner_q == OWN_D);
    c_rdata   = c_rsp_valid ? rsp_data : '0;
    d_rdata   = d_rsp_valid ? rsp_data : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed steps plus randomized traffic
// against a reference memory and grant model; honours DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req_valid, c_req_ready, c_we, c_rsp_valid;
  logic [1:0]  c_size;
  logic [7:0]  c_addr;
  logic [31:0] c_wdata, c_rdata;
  logic        d_req_valid, d_req_ready, d_we, d_rsp_valid;
  logic [1:0]  d_size;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  bit          last_own;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_we(c_we), .c_size(c_size),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_rsp_valid(c_rsp_valid), .c_rdata(c_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we), .d_size(d_size),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory array: byte-lane writes, read data registered one cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end
      mem_rdata <= mem[mem_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] size_mask(input logic [1:0] sz);
    if (sz == 2'd0) return 32'h0000_00FF;
    if (sz == 2'd1) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz);
    if (sz == 2'd0) return 4'b0001;
    if (sz == 2'd1) return 4'b0011;
    return 4'b1111;
  endfunction

  // Expected winner: single requester wins; ties by configured policy.
  function automatic bit pick(input bit cv, input bit dv);
    if (cv && dv) begin
`ifdef DMEM_ARB_RR_EN
      return (last_own == 1'b1) ? 1'b0 : 1'b1;
`else
      return 1'b0;
`endif
    end
    return dv;
  endfunction

  task automatic set_req(input bit port, input bit v, input bit we, input logic [1:0] sz,
                         input logic [7:0] a, input logic [31:0] wd);
    if (!port) begin
      c_req_valid = v; c_we = we; c_size = sz; c_addr = a; c_wdata = wd;
    end else begin
      d_req_valid = v; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    end
  endtask

  // Called at posedge+1 with requests already driven; returns at posedge+1 in IDLE.
  task automatic complete(input bit own, input bit we, input logic [1:0] sz,
                          input logic [7:0] a, input logic [31:0] wd);
    int waited = 0;
    logic [31:0] exp_rd;
    #1;
    while (!(own ? d_req_ready : c_req_ready) && waited < 12) begin
      @(posedge clk); #2;
      waited++;
    end
    check(own ? "d_ready" : "c_ready", {31'd0, own ? d_req_ready : c_req_ready}, 32'd1);
    if (!(own ? d_req_ready : c_req_ready)) begin
      set_req(own, 1'b0, 1'b0, 2'd0, 8'd0, 32'd0);
      return;
    end
    check("loser_ready", {31'd0, own ? c_req_ready : d_req_ready}, 32'd0);
    exp_rd = we ? 32'd0 : (ref_mem[a] & size_mask(sz));
    if (we) ref_mem[a] = (ref_mem[a] & ~size_mask(sz)) | (wd & size_mask(sz));
    last_own = own;
    @(posedge clk); #1;
    if (!own) c_req_valid = 1'b0; else d_req_valid = 1'b0;
    check("acc_mem_en", {31'd0, mem_en}, 32'd1);
    check("acc_mem_we", {31'd0, mem_we}, {31'd0, we});
    check("acc_mem_be", {28'd0, mem_be}, {28'd0, exp_be(sz)});
    check("acc_mem_addr", {24'd0, mem_addr}, {24'd0, a});
    check("acc_mem_wdata", mem_wdata, wd);
    check("acc_rsp", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd0);
    check("acc_ready", {30'd0, c_req_ready, d_req_ready}, 32'd0);
    @(posedge clk); #1;
    check("rsp_mem_en", {31'd0, mem_en}, 32'd0);
    check("rsp_valid", {30'd0, c_rsp_valid, d_rsp_valid}, own ? 32'd1 : 32'd2);
    check("rsp_rdata", own ? d_rdata : c_rdata, exp_rd);
    check("rsp_other_rdata", own ? c_rdata : d_rdata, 32'd0);
    @(posedge clk); #1;
    check("post_rsp", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd0);
  endtask

  bit          pv [2];
  bit          pwe [2];
  logic [1:0]  psz [2];
  logic [7:0]  pa [2];
  logic [31:0] pwd [2];

  initial begin
    bit own;
    // Reset held with both ports requesting: nothing may be granted or strobed.
    reset = 1'b1;
    last_own = 1'b1;
    set_req(1'b0, 1'b1, 1'b1, 2'd2, 8'h10, 32'hDEADBEEF);
    set_req(1'b1, 1'b1, 1'b1, 2'd2, 8'h20, 32'h11223344);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_ready", {30'd0, c_req_ready, d_req_ready}, 32'd0);
      check("rst_rsp", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd0);
      check("rst_mem_en", {31'd0, mem_en}, 32'd0);
      check("rst_rdata", c_rdata | d_rdata, 32'd0);
    end
    reset = 1'b0;
    check("first_tie_c", {31'd0, pick(1'b1, 1'b1)}, 32'd0);
    complete(pick(1'b1, 1'b1), 1'b1, 2'd2, 8'h10, 32'hDEADBEEF);
    complete(pick(1'b0, 1'b1), 1'b1, 2'd2, 8'h20, 32'h11223344);

    // Word load back; byte store merge; word and byte readback.
    set_req(1'b0, 1'b1, 1'b0, 2'd2, 8'h10, 32'h0);
    complete(1'b0, 1'b0, 2'd2, 8'h10, 32'h0);
    set_req(1'b1, 1'b1, 1'b1, 2'd0, 8'h20, 32'h000000AB);
    complete(1'b1, 1'b1, 2'd0, 8'h20, 32'h000000AB);
    set_req(1'b1, 1'b1, 1'b0, 2'd2, 8'h20, 32'h0);
    complete(1'b1, 1'b0, 2'd2, 8'h20, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 2'd0, 8'h20, 32'h0);
    complete(1'b1, 1'b0, 2'd0, 8'h20, 32'h0);

    // Four contended transactions.
    set_req(1'b0, 1'b1, 1'b0, 2'd2, 8'h10, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 2'd2, 8'h20, 32'h0);
    for (int i = 0; i < 4; i++) begin
      own = pick(1'b1, 1'b1);
      complete(own, 1'b0, 2'd2, own ? 8'h20 : 8'h10, 32'h0);
      set_req(own, 1'b1, 1'b0, 2'd2, own ? 8'h20 : 8'h10, 32'h0);
    end
    c_req_valid = 1'b0;
    d_req_valid = 1'b0;
    @(posedge clk); #1;

    // Reset during the response cycle of a C load.
    set_req(1'b0, 1'b1, 1'b0, 2'd2, 8'h10, 32'h0);
    #1;
    check("r5_ready", {31'd0, c_req_ready}, 32'd1);
    @(posedge clk); #1;
    c_req_valid = 1'b0;
    check("r5_access", {31'd0, mem_en}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("r5_no_rsp", {31'd0, c_rsp_valid}, 32'd0);
    check("r5_rdata", c_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_own = 1'b1;
    check("r5_idle_rsp", {31'd0, c_rsp_valid}, 32'd0);
    check("r5_idle_en", {31'd0, mem_en}, 32'd0);
    set_req(1'b0, 1'b1, 1'b0, 2'd2, 8'h10, 32'h0);
    complete(1'b0, 1'b0, 2'd2, 8'h10, 32'h0);

    // Half store and size-3 store, then readback.
    set_req(1'b0, 1'b1, 1'b1, 2'd1, 8'h30, 32'h5555BEEF);
    complete(1'b0, 1'b1, 2'd1, 8'h30, 32'h5555BEEF);
    set_req(1'b0, 1'b1, 1'b0, 2'd1, 8'h30, 32'h0);
    complete(1'b0, 1'b0, 2'd1, 8'h30, 32'h0);
    set_req(1'b0, 1'b1, 1'b1, 2'd3, 8'h31, 32'h12345678);
    complete(1'b0, 1'b1, 2'd3, 8'h31, 32'h12345678);
    set_req(1'b1, 1'b1, 1'b0, 2'd3, 8'h31, 32'h0);
    complete(1'b1, 1'b0, 2'd3, 8'h31, 32'h0);

    // Random traffic over a small initialised window; pending requests are held.
    for (int i = 0; i < 8; i++) begin
      set_req(i[0], 1'b1, 1'b1, 2'd2, 8'h40 + 8'(i), $urandom);
      complete(i[0], 1'b1, 2'd2, 8'h40 + 8'(i), i[0] ? d_wdata : c_wdata);
    end
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && ($urandom_range(0, 1) == 1 || (p == 1 && !pv[0]))) begin
          pv[p]  = 1'b1;
          pwe[p] = 1'($urandom_range(0, 1));
          psz[p] = 2'($urandom_range(0, 3));
          pa[p]  = 8'h40 + 8'($urandom_range(0, 7));
          pwd[p] = $urandom;
        end
        set_req(p[0], pv[p], pwe[p], psz[p], pa[p], pwd[p]);
      end
      own = pick(pv[0], pv[1]);
      complete(own, pwe[own], psz[own], pa[own], pwd[own]);
      pv[own] = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      if (pv[p]) begin
        set_req(p[0], 1'b1, pwe[p], psz[p], pa[p], pwd[p]);
        complete(p[0], pwe[p], psz[p], pa[p], pwd[p]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
